// File: rtl/and_gate_if.sv
// and_gate operand/result bundle.
// master drives operands, slave is the gate bank.
interface and_gate_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op_sel;
  logic             out_valid;
  logic [WIDTH-1:0] y_and;
  logic [WIDTH-1:0] y_nand;
  logic [WIDTH-1:0] y_nor;
  logic [WIDTH-1:0] y;
  logic             y_all_ones;
  logic             y_zero;
  logic             op_err;

  modport master (
    output in_valid, a, b, op_sel,
    input  out_valid, y_and, y_nand, y_nor,
    input  y, y_all_ones, y_zero, op_err
  );

  modport slave (
    input  in_valid, a, b, op_sel,
    output out_valid, y_and, y_nand, y_nor,
    output y, y_all_ones, y_zero, op_err
  );
endinterface

// File: rtl/and_gate.sv
// Registered AND/NAND/NOR bank with selectable primary result.
// AND_GATE_IN_REG_EN adds an input register stage (latency 2).
module and_gate #(
  parameter int WIDTH = 1
) (
  input logic     clk,
  input logic     rst_n,
  and_gate_if.slave bus
);
  logic             s_v;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic [1:0]       s_op;

`ifdef AND_GATE_IN_REG_EN
  logic             in_v_q;
  logic [WIDTH-1:0] in_a_q;
  logic [WIDTH-1:0] in_b_q;
  logic [1:0]       in_op_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_v_q  <= 1'b0;
      in_a_q  <= '0;
      in_b_q  <= '0;
      in_op_q <= 2'b00;
    end else begin
      in_v_q  <= bus.in_valid;
      in_a_q  <= bus.a;
      in_b_q  <= bus.b;
      in_op_q <= bus.op_sel;
    end
  end

  assign s_v  = in_v_q;
  assign s_a  = in_a_q;
  assign s_b  = in_b_q;
  assign s_op = in_op_q;
`else
  assign s_v  = bus.in_valid;
  assign s_a  = bus.a;
  assign s_b  = bus.b;
  assign s_op = bus.op_sel;
`endif

  logic             vld_q;
  logic [WIDTH-1:0] and_q, and_d;
  logic [WIDTH-1:0] nand_q, nand_d;
  logic [WIDTH-1:0] nor_q, nor_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             ones_q, ones_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  always_comb begin
    and_d  = s_a & s_b;
    nand_d = ~(s_a & s_b);
    nor_d  = ~(s_a | s_b);
    y_d    = '0;
    err_d  = 1'b0;
    unique case (1'b1)
      (s_op == 2'b00): y_d = and_d;
      (s_op == 2'b01): y_d = nand_d;
      (s_op == 2'b10): y_d = nor_d;
      default:         err_d = 1'b1;
    endcase
    ones_d = &y_d;
    zero_d = ~|y_d;
  end

  // Results hold on idle cycles; only the strobe drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      and_q  <= '0;
      nand_q <= '0;
      nor_q  <= '0;
      y_q    <= '0;
      ones_q <= 1'b0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= s_v;
      if (s_v) begin
        and_q  <= and_d;
        nand_q <= nand_d;
        nor_q  <= nor_d;
        y_q    <= y_d;
        ones_q <= ones_d;
        zero_q <= zero_d;
        err_q  <= err_d;
      end
    end
  end

  assign bus.out_valid  = vld_q;
  assign bus.y_and      = and_q;
  assign bus.y_nand     = nand_q;
  assign bus.y_nor      = nor_q;
  assign bus.y          = y_q;
  assign bus.y_all_ones = ones_q;
  assign bus.y_zero     = zero_q;
  assign bus.op_err     = err_q;
endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate, WIDTH=8 and WIDTH=1 side by side.
// The WIDTH=1 instance sees bit 0 of the 8-bit operands.
module tb_and_gate;
`ifdef AND_GATE_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int         due;
    logic [7:0] and8, nand8, nor8, y8;
    logic       ao8, z8, err;
    logic       and1, nand1, nor1, y1;
    logic       ao1, z1;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   passed;
  exp_t sb[$];
  exp_t held;
  exp_t zero_e;
  logic exp_ov;

  and_gate_if #(.WIDTH(8)) if8 ();
  and_gate_if #(.WIDTH(1)) if1 ();

  and_gate #(.WIDTH(8)) u8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if8.slave)
  );

  and_gate #(.WIDTH(1)) u1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] op
  );
    exp_t e;
    e = zero_e;
    e.and8  = a & b;
    e.nand8 = ~(a & b);
    e.nor8  = ~(a | b);
    e.and1  = a[0] & b[0];
    e.nand1 = ~(a[0] & b[0]);
    e.nor1  = ~(a[0] | b[0]);
    case (op)
      2'd0: begin e.y8 = e.and8;  e.y1 = e.and1;  end
      2'd1: begin e.y8 = e.nand8; e.y1 = e.nand1; end
      2'd2: begin e.y8 = e.nor8;  e.y1 = e.nor1;  end
      default: begin
        e.y8 = 8'h00; e.y1 = 1'b0; e.err = 1'b1;
      end
    endcase
    e.ao8 = (e.y8 == 8'hFF);
    e.z8  = (e.y8 == 8'h00);
    e.ao1 = e.y1;
    e.z1  = ~e.y1;
    return e;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step(
    input logic       r,
    input logic       v,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] op,
    input string      tag
  );
    exp_t e;
    rst_n       = r;
    if8.in_valid = v;
    if8.a        = a;
    if8.b        = b;
    if8.op_sel   = op;
    if1.in_valid = v;
    if1.a        = a[0];
    if1.b        = b[0];
    if1.op_sel   = op;
    if (r && v) begin
      e = model(a, b, op);
      e.due = cyc + LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    if (!r) begin
      sb.delete();
      held = zero_e;
    end
    #1;
    exp_ov = (sb.size() > 0) && (sb[0].due == cyc);
    chk({tag, ":ov8"}, 64'(if8.out_valid), 64'(exp_ov));
    chk({tag, ":ov1"}, 64'(if1.out_valid), 64'(exp_ov));
    if (exp_ov) held = sb.pop_front();
    chk({tag, ":and8"},  64'(if8.y_and),      64'(held.and8));
    chk({tag, ":nand8"}, 64'(if8.y_nand),     64'(held.nand8));
    chk({tag, ":nor8"},  64'(if8.y_nor),      64'(held.nor8));
    chk({tag, ":y8"},    64'(if8.y),          64'(held.y8));
    chk({tag, ":ao8"},   64'(if8.y_all_ones), 64'(held.ao8));
    chk({tag, ":z8"},    64'(if8.y_zero),     64'(held.z8));
    chk({tag, ":err8"},  64'(if8.op_err),     64'(held.err));
    chk({tag, ":and1"},  64'(if1.y_and),      64'(held.and1));
    chk({tag, ":nand1"}, 64'(if1.y_nand),     64'(held.nand1));
    chk({tag, ":nor1"},  64'(if1.y_nor),      64'(held.nor1));
    chk({tag, ":y1"},    64'(if1.y),          64'(held.y1));
    chk({tag, ":ao1"},   64'(if1.y_all_ones), 64'(held.ao1));
    chk({tag, ":z1"},    64'(if1.y_zero),     64'(held.z1));
    chk({tag, ":err1"},  64'(if1.op_err),     64'(held.err));
  endtask

  initial begin
    cyc    = 0;
    total  = 0;
    passed = 0;
    zero_e = '{default: '0};
    held   = zero_e;
    rst_n  = 1'b0;

    // reset wins over in_valid
    step(0, 1, 8'hFF, 8'hFF, 2'd0, "rst0");
    step(0, 1, 8'hFF, 8'hFF, 2'd0, "rst1");

    // truth tables on bit 0, background bits vary
    for (int op = 0; op < 3; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        step(1, 1, 8'hA4 | 8'(ab[1]), 8'h6C | 8'(ab[0]),
             2'(op), "tt");
      end
    end

    step(1, 1, 8'hF0, 8'h3C, 2'd0, "f0_3c");
    step(1, 1, 8'hFF, 8'hFF, 2'd0, "ones");
    step(1, 1, 8'hFF, 8'h00, 2'd3, "op11");
    step(1, 1, 8'h0F, 8'h0E, 2'd1, "nand");

    // hold while idle with moving operands
    step(1, 0, 8'h12, 8'h34, 2'd2, "hold0");
    step(1, 0, 8'h56, 8'h78, 2'd0, "hold1");
    step(1, 0, 8'h9A, 8'hBC, 2'd3, "hold2");
    step(1, 0, 8'hDE, 8'hF1, 2'd1, "hold3");

    // back-to-back, then reset mid-stream
    step(1, 1, 8'h11, 8'h33, 2'd0, "b2b0");
    step(1, 1, 8'h55, 8'h0F, 2'd2, "b2b1");
    step(1, 1, 8'hC3, 8'h3C, 2'd1, "b2b2");
    step(0, 1, 8'hFF, 8'hFF, 2'd0, "midrst");
    step(1, 0, 8'hFF, 8'hFF, 2'd0, "post0");
    step(1, 1, 8'h81, 8'h01, 2'd0, "post1");
    step(1, 0, 8'h00, 8'h00, 2'd0, "drain0");
    step(1, 0, 8'h00, 8'h00, 2'd0, "drain1");
    step(1, 0, 8'h00, 8'h00, 2'd0, "drain2");

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/and_gate.md
# and_gate

Registered two-operand bitwise gate bank computing AND, NAND and NOR of two WIDTH-bit operands in parallel, with a selectable primary result and a valid strobe. It serves as the synchronous logic-primitive stage in datapaths that need clocked gate results with a defined reset state and fixed latency. A single-bit instance (WIDTH=1) reproduces the classic 2-input gate truth tables.

## Interface
- WIDTH, 1, operand and result width in bits (legal 1..64)
- clk  input  1  rising-edge clock; sole clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  operands/op_sel qualified this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op_sel  input  2  primary result select: 00 AND, 01 NAND, 10 NOR, 11 reserved
- out_valid  output  1  registered results valid
- y_and  output  WIDTH  a & b
- y_nand  output  WIDTH  ~(a & b)
- y_nor  output  WIDTH  ~(a | b)
- y  output  WIDTH  result chosen by op_sel
- y_all_ones  output  1  &y (reduction AND of y)
- y_zero  output  1  ~|y (y all zeros)
- op_err  output  1  op_sel was 11 for the captured sample

## Operation
- Reset is synchronous, active-low; only clk is used.
- When rst_n=0 at a rising edge: every output (out_valid, y_and, y_nand, y_nor, y, y_all_ones, y_zero, op_err) becomes 0. Reset value 0 holds for y_nand/y_nor even though the logical NAND/NOR of zero operands is 1.
- When rst_n=1 and in_valid=1 at a rising edge: capture y_and=a&b, y_nand=~(a&b), y_nor=~(a|b), all bitwise over WIDTH bits; y per op_sel; y_all_ones and y_zero computed from the new y; op_err=(op_sel==11); out_valid=1.
- op_sel=11: y=0, y_all_ones=0, y_zero=1, op_err=1; y_and/y_nand/y_nor still updated normally.
- When rst_n=1 and in_valid=0: out_valid=0; all result outputs and op_err hold their previous values.
- Inputs X/Z are not sanitized; results follow standard bitwise semantics.
- No backpressure: each accepted sample appears exactly once, in order. Back-to-back in_valid gives one result per cycle.

## Timing
- Latency: 1 clock from in_valid sampled to out_valid/results (2 with AND_GATE_IN_REG_EN).
- Throughput: 1 sample per clock, no bubbles.
- out_valid is a single-cycle pulse per accepted sample; high continuously under back-to-back input.
- Reset mid-stream: samples in flight are discarded; out_valid=0 the cycle after the reset edge; first post-reset result appears the configured latency after the first in_valid sampled with rst_n=1.
- rst_n and in_valid asserted on the same edge: reset wins.
- All outputs driven directly from flops; no combinational input-to-output path.

## Configuration
- AND_GATE_IN_REG_EN defined: a, b, op_sel and in_valid are first registered (input stage reset to 0 / in_valid 0 by rst_n); latency becomes 2 clocks; hold behaviour on in_valid=0 applies at the output stage using the delayed valid.
- Not defined: no input stage; latency 1 clock as above.
- Port list and reset values identical in both builds.

## Test plan
- Reset: rst_n=0 for 2 cycles with a=1,b=1,in_valid=1 -> all outputs 0, out_valid=0 throughout.
- WIDTH=1 truth table, op_sel=00 then 01 then 10, (a,b)=00,01,10,11 each with in_valid=1 -> y_and=0,0,0,1; y_nand=1,1,1,0; y_nor=1,0,0,0; y matches selected column one cycle later.
- WIDTH=8, a=8'hF0, b=8'h3C, op_sel=00 -> y_and=8'h30, y_nand=8'hCF, y_nor=8'h03, y=8'h30, y_zero=0, y_all_ones=0; a=b=8'hFF op_sel=00 -> y_all_ones=1.
- op_sel=11, a=8'hFF, b=8'h00 -> y=0, y_zero=1, op_err=1, y_nor=8'h00, y_nand=8'hFF.
- Hold: accept one sample, then in_valid=0 for 3 cycles while changing a/b -> out_valid=0, results unchanged.
- Reset mid-stream: back-to-back samples, rst_n=0 for one edge -> outputs 0 next cycle; with AND_GATE_IN_REG_EN defined, in-flight sample never appears and latency measures 2.
